if_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns fetch PC, masters the shared bus for instruction reads, buffers fetched

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_prefetch_buf.sv | 61 ++++++
 rtl/if_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    localparam word_data_t ISA_NOP  = 32'h0;
    localparam logic       READ     = 1'b1;
    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        IF_STATE_IDLE,
        IF_STATE_REQ,
        IF_STATE_ACCESS
    } if_state_e;

    typedef struct packed {
        word_addr_t pc;
        word_data_t insn;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_prefetch_buf.sv
// Prefetch FIFO of {pc, insn} entries with synchronous clear and active-low reset.
module if_prefetch_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  fetch_entry_t     wr_entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer and occupancy; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wr_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: bus master for instruction reads, prefetch buffer, IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter word_addr_t  RESET_VECTOR = 30'h0,
    parameter int unsigned BUF_DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] new_pc,
    input  logic                   br_taken,
    input  logic [WORD_ADDR_W-1:0] br_addr,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    output logic [WORD_ADDR_W-1:0] if_pc,
    output logic [WORD_DATA_W-1:0] if_insn,
    output logic                   if_en,
    output logic                   busy
);
    localparam int unsigned      CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    if_state_e        state_q, state_d;
    word_addr_t       fetch_pc_q, fetch_pc_d, acc_addr_q, acc_addr_d;
    word_addr_t       if_pc_q, if_pc_d, fetch_src, target;
    word_data_t       if_insn_q, if_insn_d;
    logic             discard_q, discard_d, if_en_q, if_en_d;
    logic             redir, rdy_hit, push, pop, start, room, buf_empty;
    logic [CNT_W-1:0] buf_count, count_nx;
    fetch_entry_t     head, wr_entry;

    assign redir    = flush | (br_taken & ~stall);
    assign target   = flush ? new_pc : br_addr;
    assign rdy_hit  = (state_q == IF_STATE_ACCESS) && !bus_rdy_;
    assign push     = rdy_hit & ~discard_q & ~redir;
    assign pop      = ~flush & ~stall & ~br_taken & ~buf_empty;
    assign count_nx = redir ? '0 : buf_count + CNT_W'(push) - CNT_W'(pop);
    assign room     = count_nx < DEPTH_CNT;
    assign wr_entry = '{pc: acc_addr_q, insn: bus_rd_data};

    if_prefetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (redir),
        .push_i     (push),
        .pop_i      (pop),
        .wr_entry_i (wr_entry),
        .head_o     (head),
        .count_o    (buf_count),
        .empty_o    (buf_empty)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IF_STATE_IDLE;
        else        state_q <= state_d;
    end

    // Fetch FSM next state: credit-limited request, back-to-back access while space and grant remain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_STATE_IDLE:   if (!redir && buf_count < DEPTH_CNT) state_d = IF_STATE_REQ;
            IF_STATE_REQ:    if (!redir && !bus_grnt_) state_d = IF_STATE_ACCESS;
            IF_STATE_ACCESS: if (rdy_hit) state_d = (!bus_grnt_ && room) ? IF_STATE_ACCESS : IF_STATE_IDLE;
            default:         state_d = IF_STATE_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        bus_req_    = DISABLE_;
        bus_as_     = DISABLE_;
        bus_addr    = '0;
        busy        = 1'b0;
        bus_rw      = READ;
        bus_wr_data = '0;
        case (state_q)
            IF_STATE_REQ: begin
                bus_req_ = ENABLE_;
                busy     = 1'b1;
            end
            IF_STATE_ACCESS: begin
                bus_req_ = ENABLE_;
                bus_as_  = ENABLE_;
                bus_addr = acc_addr_q;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch address bookkeeping. The in-flight address lives in acc_addr so fetch_pc can take a
    // redirect target mid-access; fetch_pc advances when an access starts, not when it completes.
    always_comb begin
        fetch_src  = redir ? target : fetch_pc_q;
        start      = (state_d == IF_STATE_ACCESS) && ((state_q == IF_STATE_REQ) || rdy_hit);
        fetch_pc_d = fetch_src;
        acc_addr_d = acc_addr_q;
        if (start) begin
            acc_addr_d = fetch_src;
            fetch_pc_d = fetch_src + WORD_ADDR_W'(1);
        end
        discard_d = discard_q;
        if (rdy_hit)                                  discard_d = 1'b0;
        else if (redir && state_q == IF_STATE_ACCESS) discard_d = 1'b1;
    end

    // IF/ID register next value: flush > stall > branch > FIFO head > bubble.
    always_comb begin
        if_pc_d   = if_pc_q;
        if_insn_d = if_insn_q;
        if_en_d   = if_en_q;
        if (flush) begin
            if_en_d   = 1'b0;
            if_insn_d = ISA_NOP;
            if_pc_d   = new_pc;
        end else if (!stall) begin
            if (br_taken || buf_empty) begin
                if_en_d   = 1'b0;
                if_insn_d = ISA_NOP;
            end else begin
                if_en_d   = 1'b1;
                if_pc_d   = head.pc;
                if_insn_d = head.insn;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_VECTOR;
            acc_addr_q <= '0;
            discard_q  <= 1'b0;
            if_pc_q    <= RESET_VECTOR;
            if_insn_q  <= ISA_NOP;
            if_en_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            acc_addr_q <= acc_addr_d;
            discard_q  <= discard_d;
            if_pc_q    <= if_pc_d;
            if_insn_q  <= if_insn_d;
            if_en_q    <= if_en_d;
        end
    end

    assign if_pc   = if_pc_q;
    assign if_insn = if_insn_q;
    assign if_en   = if_en_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle vector table plus a slow-bus sequence.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [29:0] new_pc, br_addr;
    logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en, busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_VECTOR(30'h0), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en       (if_en),
        .busy        (busy)
    );

    // Memory model: instruction word is a fixed function of its address.
    function automatic logic [31:0] mk(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    always_comb bus_rd_data = mk(bus_addr);

    typedef struct {
        logic        rst_n, st, fl;
        logic [29:0] npc;
        logic        br;
        logic [29:0] ba;
        logic        rdy_;
        logic        e_req_, e_as_;
        logic [29:0] e_addr;
        logic        e_en;
        logic [29:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic st, input logic fl, input logic [29:0] np,
                       input logic br, input logic [29:0] ba, input logic rdy,
                       input logic rq, input logic as_, input logic [29:0] ad,
                       input logic en, input logic [29:0] pc, input logic by);
        vec_t v;
        v.rst_n = r;  v.st = st;  v.fl = fl;  v.npc = np;  v.br = br;  v.ba = ba;  v.rdy_ = rdy;
        v.e_req_ = rq; v.e_as_ = as_; v.e_addr = ad; v.e_en = en; v.e_pc = pc; v.e_busy = by;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned waitc, as0, nvalid;
    logic [29:0] exp_pc;
    logic [31:0] e_insn;

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;

        //   rst st fl npc          br ba      rdy_ | req_ as_ addr         en pc           busy
        add(0, 0, 0, 30'h0,        0, 30'h0,  0,    1, 1, 30'h0,        0, 30'h0,        0);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 1, 30'h0,        0, 30'h0,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h0,        0, 30'h0,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h1,        0, 30'h0,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h2,        1, 30'h0,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h3,        1, 30'h1,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h4,        1, 30'h2,        1);
        for (int k = 0; k < 5; k++)
            add(1, 1, 0, 30'h0,    0, 30'h0,  0,    1, 1, 30'h0,        1, 30'h2,        0);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    1, 1, 30'h0,        1, 30'h3,        0);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 1, 30'h0,        1, 30'h4,        1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h5,        0, 30'h4,        1);
        add(1, 0, 1, 30'h100,      0, 30'h0,  1,    0, 0, 30'h5,        0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h100,      0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h101,      0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h102,      1, 30'h100,      1);
        add(1, 1, 0, 30'h0,        1, 30'h40, 0,    1, 1, 30'h0,        1, 30'h100,      0);
        add(1, 0, 0, 30'h0,        1, 30'h40, 0,    1, 1, 30'h0,        0, 30'h100,      0);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 1, 30'h0,        0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h40,       0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h41,       0, 30'h100,      1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h42,       1, 30'h40,       1);
        add(1, 0, 1, 30'h3FFFFFFF, 1, 30'h55, 0,    0, 0, 30'h3FFFFFFF, 0, 30'h3FFFFFFF, 1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h0,        0, 30'h3FFFFFFF, 1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h1,        1, 30'h3FFFFFFF, 1);
        add(1, 0, 0, 30'h0,        0, 30'h0,  0,    0, 0, 30'h2,        1, 30'h0,        1);
        add(0, 0, 0, 30'h0,        0, 30'h0,  0,    1, 1, 30'h0,        0, 30'h0,        0);

        foreach (vq[i]) begin
            reset = vq[i].rst_n; stall = vq[i].st; flush = vq[i].fl; new_pc = vq[i].npc;
            br_taken = vq[i].br; br_addr = vq[i].ba; bus_rdy_ = vq[i].rdy_;
            step();
            e_insn = vq[i].e_en ? mk(vq[i].e_pc) : 32'h0;
            check($sformatf("v%0d bus_req_", i), 64'(bus_req_), 64'(vq[i].e_req_));
            check($sformatf("v%0d bus_as_", i),  64'(bus_as_),  64'(vq[i].e_as_));
            check($sformatf("v%0d bus_addr", i), 64'(bus_addr), 64'(vq[i].e_addr));
            check($sformatf("v%0d if_en", i),    64'(if_en),    64'(vq[i].e_en));
            check($sformatf("v%0d if_pc", i),    64'(if_pc),    64'(vq[i].e_pc));
            check($sformatf("v%0d if_insn", i),  64'(if_insn),  64'(e_insn));
            check($sformatf("v%0d busy", i),     64'(busy),     64'(vq[i].e_busy));
        end
        check("bus_rw", 64'(bus_rw), 64'd1);
        check("bus_wr_data", 64'(bus_wr_data), 64'd0);

        // Slow bus: rdy_ asserted on the fourth strobe cycle of each access.
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_rdy_ = 1'b1;
        step();
        reset = 1'b1;
        waitc = 0; as0 = 0; nvalid = 0; exp_pc = 30'h0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (!bus_as_ && bus_addr == 30'h0) as0++;
            if (if_en) begin
                check($sformatf("slow if_pc #%0d", nvalid), 64'(if_pc), 64'(exp_pc));
                check($sformatf("slow if_insn #%0d", nvalid), 64'(if_insn), 64'(mk(exp_pc)));
                exp_pc = exp_pc + 30'h1;
                nvalid++;
            end
            if (!bus_as_) waitc++;
            if (waitc == 4) begin
                bus_rdy_ = 1'b0;
                waitc = 0;
            end else begin
                bus_rdy_ = 1'b1;
            end
        end
        check("slow strobe cycles addr0", 64'(as0), 64'd4);
        check("slow valid count >= 3", 64'(nvalid >= 3), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
